// File: rtl/bit_population_counter_pkg.sv
// rtl/bit_population_counter_pkg.sv - shared types and derived sizes for the popcount stream engine
package bit_population_counter_pkg;

  typedef enum logic {
    MODE_ONES  = 1'b0,
    MODE_ZEROS = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_e;

  function automatic int word_latency(input int width, input int chunk_w);
    return 1 + $clog2(width / chunk_w);
  endfunction

  function automatic int acc_width(input int width, input int max_words);
    return $clog2(width * max_words) + 1;
  endfunction

endpackage

// File: rtl/bit_population_counter_tree.sv
// rtl/bit_population_counter_tree.sv - leaf popcounts and pipelined adder tree with aligned sideband
module bit_population_counter_tree
  import bit_population_counter_pkg::*;
#(
  parameter int WIDTH   = 256,
  parameter int CHUNK_W = 16
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic [WIDTH-1:0]           data,
  input  logic                       val,
  input  logic                       sop,
  input  logic                       eop,
  input  mode_e                      mode,
  output logic [$clog2(WIDTH):0]     cnt,
  output logic                       cnt_val,
  output logic                       cnt_sop,
  output logic                       cnt_eop
);

  localparam int N     = WIDTH / CHUNK_W;
  localparam int L     = word_latency(WIDTH, CHUNK_W) - 1;
  localparam int OW    = $clog2(WIDTH) + 1;
  localparam int NODES = 2 * N - 1;

  if ((WIDTH % CHUNK_W) != 0 || (N & (N - 1)) != 0) begin : gen_bad_params
    $error("WIDTH must be a multiple of CHUNK_W with a power-of-two ratio");
  end

  logic [WIDTH-1:0] word;
  logic [L:0]       v_pipe;
  logic [L:0]       s_pipe;
  logic [L:0]       e_pipe;
  logic [OW-1:0]    node [NODES];

  assign word = (mode == MODE_ZEROS) ? ~data : data;

  always_ff @(posedge clk) begin
    if (srst) begin
      v_pipe <= '0;
      s_pipe <= '0;
      e_pipe <= '0;
    end else begin
      v_pipe[0] <= val;
      s_pipe[0] <= val & sop;
      e_pipe[0] <= val & eop;
      for (int k = 1; k <= L; k++) begin
        v_pipe[k] <= v_pipe[k-1];
        s_pipe[k] <= s_pipe[k-1];
        e_pipe[k] <= e_pipe[k-1];
      end
    end
  end

  // Heap-ordered tree: node i has children 2i+1 / 2i+2, leaves occupy N-1..2N-2.
  // Each level only loads when a valid word reaches it, so the root holds between words.
  for (genvar i = 0; i < NODES; i++) begin : gen_node
    localparam int LEV = $clog2(i + 2) - 1;
    if (LEV == L) begin : gen_leaf
      always_ff @(posedge clk) begin
        if (srst) node[i] <= '0;
        else if (val) node[i] <= OW'($countones(word[(i-(N-1))*CHUNK_W +: CHUNK_W]));
      end
    end else begin : gen_sum
      always_ff @(posedge clk) begin
        if (srst) node[i] <= '0;
        else if (v_pipe[L-LEV-1]) node[i] <= node[2*i+1] + node[2*i+2];
      end
    end
  end

  assign cnt     = node[0];
  assign cnt_val = v_pipe[L];
  assign cnt_sop = s_pipe[L];
  assign cnt_eop = e_pipe[L];

endmodule

// File: rtl/bit_population_counter_stream.sv
// rtl/bit_population_counter_stream.sv - per-word popcount stream with packet accumulation and framing checks
module bit_population_counter_stream
  import bit_population_counter_pkg::*;
#(
  parameter int  WIDTH     = 256,
  parameter int  CHUNK_W   = 16,
  parameter int  MAX_WORDS = 1024,
  localparam int ACC_W     = acc_width(WIDTH, MAX_WORDS)
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   data_val_i,
  input  logic                   data_sop_i,
  input  logic                   data_eop_i,
  input  logic                   mode_i,
  output logic [$clog2(WIDTH):0] data_o,
  output logic                   data_val_o,
  output logic [ACC_W-1:0]       pkt_cnt_o,
  output logic                   pkt_val_o,
  output logic                   pkt_sat_o,
  output logic                   err_o
);

  localparam int OW = $clog2(WIDTH) + 1;

  logic [OW-1:0]    cnt;
  logic             cnt_val;
  logic             cnt_sop;
  logic             cnt_eop;
  logic [ACC_W-1:0] cnt_ext;
  logic [ACC_W:0]   sum_full;
  logic [ACC_W-1:0] sum_clamp;
  logic             sum_ovf;
  state_e           state;
  logic [ACC_W-1:0] acc;
  logic             sat;

  bit_population_counter_tree #(
    .WIDTH   (WIDTH),
    .CHUNK_W (CHUNK_W)
  ) u_tree (
    .clk     (clk_i),
    .srst    (srst_i),
    .data    (data_i),
    .val     (data_val_i),
    .sop     (data_sop_i),
    .eop     (data_eop_i),
    .mode    (mode_e'(mode_i)),
    .cnt     (cnt),
    .cnt_val (cnt_val),
    .cnt_sop (cnt_sop),
    .cnt_eop (cnt_eop)
  );

  assign data_o     = cnt;
  assign data_val_o = cnt_val;
  assign cnt_ext    = ACC_W'(cnt);

  always_comb begin
    sum_full  = {1'b0, acc} + {1'b0, cnt_ext};
    sum_ovf   = sum_full[ACC_W];
    sum_clamp = sum_ovf ? '1 : sum_full[ACC_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state     <= IDLE;
      acc       <= '0;
      sat       <= 1'b0;
      pkt_cnt_o <= '0;
      pkt_val_o <= 1'b0;
      pkt_sat_o <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      pkt_val_o <= 1'b0;
      err_o     <= 1'b0;
      if (cnt_val) begin
        if (cnt_sop) begin
          // A sop inside a packet drops the old total and restarts from this word.
          err_o <= (state == IN_PKT);
          sat   <= 1'b0;
          if (cnt_eop) begin
            pkt_cnt_o <= cnt_ext;
            pkt_sat_o <= 1'b0;
            pkt_val_o <= 1'b1;
            state     <= IDLE;
          end else begin
            acc   <= cnt_ext;
            state <= IN_PKT;
          end
        end else if (state == IDLE) begin
          err_o <= 1'b1;
        end else if (cnt_eop) begin
          pkt_cnt_o <= sum_clamp;
          pkt_sat_o <= sat | sum_ovf;
          pkt_val_o <= 1'b1;
          state     <= IDLE;
        end else begin
          acc <= sum_clamp;
          sat <= sat | sum_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_population_counter_stream.sv
// tb/tb_bit_population_counter_stream.sv - directed-vector bench for the popcount stream engine
module tb_bit_population_counter_stream;

  logic         clk = 1'b0;
  logic         srst;
  logic [255:0] data;
  logic         val, sop, eop, mode;

  logic [8:0]   data_o;
  logic         data_val_o;
  logic [18:0]  pkt_cnt_o;
  logic         pkt_val_o, pkt_sat_o, err_o;

  logic [8:0]   s_data_o;
  logic         s_data_val_o;
  logic [9:0]   s_pkt_cnt_o;
  logic         s_pkt_val_o, s_pkt_sat_o, s_err_o;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  int t;
  int t0;

  typedef struct {
    int t;
    int v;
    int s;
  } ev_t;

  ev_t dq[$];
  ev_t pq[$];
  ev_t eq[$];
  ev_t sq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_population_counter_stream dut (
    .clk_i      (clk),
    .srst_i     (srst),
    .data_i     (data),
    .data_val_i (val),
    .data_sop_i (sop),
    .data_eop_i (eop),
    .mode_i     (mode),
    .data_o     (data_o),
    .data_val_o (data_val_o),
    .pkt_cnt_o  (pkt_cnt_o),
    .pkt_val_o  (pkt_val_o),
    .pkt_sat_o  (pkt_sat_o),
    .err_o      (err_o)
  );

  bit_population_counter_stream #(.MAX_WORDS(2)) dut_sat (
    .clk_i      (clk),
    .srst_i     (srst),
    .data_i     (data),
    .data_val_i (val),
    .data_sop_i (sop),
    .data_eop_i (eop),
    .mode_i     (mode),
    .data_o     (s_data_o),
    .data_val_o (s_data_val_o),
    .pkt_cnt_o  (s_pkt_cnt_o),
    .pkt_val_o  (s_pkt_val_o),
    .pkt_sat_o  (s_pkt_sat_o),
    .err_o      (s_err_o)
  );

  always @(negedge clk) begin
    if (data_val_o)  dq.push_back('{cyc, int'(data_o), 0});
    if (pkt_val_o)   pq.push_back('{cyc, int'(pkt_cnt_o), int'(pkt_sat_o)});
    if (err_o)       eq.push_back('{cyc, 0, 0});
    if (s_pkt_val_o) sq.push_back('{cyc, int'(s_pkt_cnt_o), int'(s_pkt_sat_o)});
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    dq.delete();
    pq.delete();
    eq.delete();
    sq.delete();
  endtask

  task automatic send(input logic [255:0] d, input logic s, input logic e, input logic m,
                      output int tstamp);
    @(posedge clk);
    #1;
    data = d; val = 1'b1; sop = s; eop = e; mode = m;
    tstamp = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      val = 1'b0; sop = 1'b0; eop = 1'b0; mode = 1'b0; data = '0;
    end
  endtask

  initial begin
    srst = 1'b1; data = '0; val = 1'b0; sop = 1'b0; eop = 1'b0; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    check("rst_data", data_o, 0);
    check("rst_dval", data_val_o, 0);
    check("rst_pcnt", pkt_cnt_o, 0);
    check("rst_pval", pkt_val_o, 0);
    check("rst_psat", pkt_sat_o, 0);
    check("rst_err", err_o, 0);

    // Single all-ones word packet: latency 5 for the word, 6 for the packet.
    clear_logs();
    send('1, 1'b1, 1'b1, 1'b0, t0);
    idle(10);
    check("s1_nd", dq.size(), 1);
    check("s1_dv", dq.size() > 0 ? dq[0].v : -1, 256);
    check("s1_dt", dq.size() > 0 ? dq[0].t - t0 : -1, 5);
    check("s1_np", pq.size(), 1);
    check("s1_pv", pq.size() > 0 ? pq[0].v : -1, 256);
    check("s1_pt", pq.size() > 0 ? pq[0].t - t0 : -1, 6);
    check("s1_err", eq.size(), 0);

    // Three words with mixed modes and a gap inside the packet.
    clear_logs();
    send(256'h1, 1'b1, 1'b0, 1'b0, t);
    send('1, 1'b0, 1'b0, 1'b0, t);
    idle(2);
    send('0, 1'b0, 1'b1, 1'b1, t);
    idle(10);
    check("s2_nd", dq.size(), 3);
    check("s2_d0", dq.size() > 0 ? dq[0].v : -1, 1);
    check("s2_d1", dq.size() > 1 ? dq[1].v : -1, 256);
    check("s2_d2", dq.size() > 2 ? dq[2].v : -1, 256);
    check("s2_np", pq.size(), 1);
    check("s2_pv", pq.size() > 0 ? pq[0].v : -1, 513);
    check("s2_ps", pq.size() > 0 ? pq[0].s : -1, 0);
    check("s2_err", eq.size(), 0);

    // Orphan word while idle.
    clear_logs();
    send(256'hF, 1'b0, 1'b0, 1'b0, t0);
    idle(10);
    check("s3_nd", dq.size(), 1);
    check("s3_dv", dq.size() > 0 ? dq[0].v : -1, 4);
    check("s3_dt", dq.size() > 0 ? dq[0].t - t0 : -1, 5);
    check("s3_ne", eq.size(), 1);
    check("s3_et", eq.size() > 0 ? eq[0].t - t0 : -1, 6);
    check("s3_np", pq.size(), 0);

    // Restart by sop mid-packet: only the restarted single-word packet is reported.
    clear_logs();
    send(256'h3FF, 1'b1, 1'b0, 1'b0, t);
    send(256'hFFFFF, 1'b0, 1'b0, 1'b0, t);
    send(256'h1F, 1'b1, 1'b1, 1'b0, t);
    idle(10);
    check("s4_nd", dq.size(), 3);
    check("s4_ne", eq.size(), 1);
    check("s4_np", pq.size(), 1);
    check("s4_pv", pq.size() > 0 ? pq[0].v : -1, 5);
    check("s4_hold_d", data_o, 5);
    check("s4_hold_p", pkt_cnt_o, 5);

    // Saturation on the 10-bit accumulator instance; the wide instance sees 1280.
    clear_logs();
    for (int i = 0; i < 5; i++) send('1, i == 0, i == 4, 1'b0, t);
    idle(10);
    check("s5_ns", sq.size(), 1);
    check("s5_sv", sq.size() > 0 ? sq[0].v : -1, 1023);
    check("s5_ss", sq.size() > 0 ? sq[0].s : -1, 1);
    check("s5_wv", pq.size() > 0 ? pq[0].v : -1, 1280);
    check("s5_ws", pq.size() > 0 ? pq[0].s : -1, 0);
    clear_logs();
    send(256'h3, 1'b1, 1'b1, 1'b0, t);
    idle(10);
    check("s5_ns2", sq.size(), 1);
    check("s5_sv2", sq.size() > 0 ? sq[0].v : -1, 2);
    check("s5_ss2", sq.size() > 0 ? sq[0].s : -1, 0);

    // Reset in the middle of a packet, then a clean packet.
    clear_logs();
    send(256'hFF, 1'b1, 1'b0, 1'b0, t);
    send(256'hF, 1'b0, 1'b0, 1'b0, t);
    @(posedge clk);
    #1 val = 1'b0; sop = 1'b0; eop = 1'b0; srst = 1'b1;
    @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    check("s6_data", data_o, 0);
    check("s6_dval", data_val_o, 0);
    check("s6_pcnt", pkt_cnt_o, 0);
    check("s6_scnt", s_pkt_cnt_o, 0);
    check("s6_err", err_o, 0);
    idle(10);
    check("s6_nd", dq.size(), 0);
    check("s6_np", pq.size(), 0);
    check("s6_ne", eq.size(), 0);
    clear_logs();
    send(256'hFFFF, 1'b1, 1'b0, 1'b0, t);
    send(256'h1, 1'b0, 1'b1, 1'b0, t);
    idle(10);
    check("s6_np2", pq.size(), 1);
    check("s6_pv2", pq.size() > 0 ? pq[0].v : -1, 17);
    check("s6_ne2", eq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
